// File: rtl/uart_tx_if.sv
// Request/status bundle between a byte source and uart_tx.
// The source drives the i_* side; the transmitter drives the o_* side.
interface uart_tx_if;
  logic       i_Enable;
  logic       i_Tx_DV;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Serial;
  logic       o_Tx_Active;
  logic       o_Tx_Done;

  modport master (
    output i_Enable,
    output i_Tx_DV,
    output i_Tx_Byte,
    input  o_Tx_Serial,
    input  o_Tx_Active,
    input  o_Tx_Done
  );

  modport slave (
    input  i_Enable,
    input  i_Tx_DV,
    input  i_Tx_Byte,
    output o_Tx_Serial,
    output o_Tx_Active,
    output o_Tx_Done
  );
endinterface

// File: rtl/uart_tx.sv
// 8-N-1 UART transmitter, LSB first, idle-high, baud = i_Clock / CLKS_PER_BIT.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic      i_Clock,
  input  logic      i_Rst_n,
  uart_tx_if.slave  tx_if
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    CLEANUP = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd4,
    CLEANUP = 3'd5
  } state_t;
`endif

  localparam logic [15:0] LP_LAST_CLK = 16'(CLKS_PER_BIT - 1);

  state_t      r_State;
  logic [15:0] r_Clk_Count;
  logic [2:0]  r_Bit_Idx;
  logic [7:0]  r_Shift;
  logic        r_Tx_Serial;
  logic        r_Tx_Active;
  logic        r_Tx_Done;
  logic        w_Bit_End;

  assign w_Bit_End = (r_Clk_Count == LP_LAST_CLK);

  // Every output is a register so the serial line never glitches.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State     <= IDLE;
      r_Clk_Count <= 16'd0;
      r_Bit_Idx   <= 3'd0;
      r_Shift     <= 8'h00;
      r_Tx_Serial <= 1'b1;
      r_Tx_Active <= 1'b0;
      r_Tx_Done   <= 1'b0;
    end else if (!tx_if.i_Enable) begin
      r_State     <= IDLE;
      r_Clk_Count <= 16'd0;
      r_Bit_Idx   <= 3'd0;
      r_Tx_Serial <= 1'b1;
      r_Tx_Active <= 1'b0;
      r_Tx_Done   <= 1'b0;
    end else begin
      case (r_State)
        IDLE: begin
          r_Tx_Serial <= 1'b1;
          r_Tx_Done   <= 1'b0;
          r_Tx_Active <= 1'b0;
          r_Clk_Count <= 16'd0;
          r_Bit_Idx   <= 3'd0;
          if (tx_if.i_Tx_DV) begin
            r_Shift     <= tx_if.i_Tx_Byte;
            r_Tx_Active <= 1'b1;
            r_Tx_Serial <= 1'b0;
            r_State     <= START;
          end
        end

        START: begin
          if (w_Bit_End) begin
            r_Clk_Count <= 16'd0;
            r_Tx_Serial <= r_Shift[0];
            r_State     <= DATA;
          end else begin
            r_Clk_Count <= r_Clk_Count + 16'd1;
          end
        end

        // The level for the following bit is launched on the same edge that ends this one.
        DATA: begin
          if (w_Bit_End) begin
            r_Clk_Count <= 16'd0;
            if (r_Bit_Idx == 3'd7) begin
              r_Bit_Idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
              r_Tx_Serial <= ^r_Shift;
              r_State     <= PARITY;
`else
              r_Tx_Serial <= 1'b1;
              r_State     <= STOP;
`endif
            end else begin
              r_Bit_Idx   <= r_Bit_Idx + 3'd1;
              r_Tx_Serial <= r_Shift[r_Bit_Idx + 3'd1];
            end
          end else begin
            r_Clk_Count <= r_Clk_Count + 16'd1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_Bit_End) begin
            r_Clk_Count <= 16'd0;
            r_Tx_Serial <= 1'b1;
            r_State     <= STOP;
          end else begin
            r_Clk_Count <= r_Clk_Count + 16'd1;
          end
        end
`endif

        STOP: begin
          r_Tx_Serial <= 1'b1;
          if (w_Bit_End) begin
            r_Clk_Count <= 16'd0;
            r_Tx_Done   <= 1'b1;
            r_Tx_Active <= 1'b0;
            r_State     <= CLEANUP;
          end else begin
            r_Clk_Count <= r_Clk_Count + 16'd1;
          end
        end

        CLEANUP: begin
          r_Tx_Serial <= 1'b1;
          r_Tx_Done   <= 1'b0;
          r_State     <= IDLE;
        end

        default: begin
          r_State     <= IDLE;
          r_Clk_Count <= 16'd0;
          r_Bit_Idx   <= 3'd0;
          r_Tx_Serial <= 1'b1;
          r_Tx_Active <= 1'b0;
          r_Tx_Done   <= 1'b0;
        end
      endcase
    end
  end

  assign tx_if.o_Tx_Serial = r_Tx_Serial;
  assign tx_if.o_Tx_Active = r_Tx_Active;
  assign tx_if.o_Tx_Done   = r_Tx_Done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4: requested bytes go into a
// scoreboard queue and are popped and checked bit-by-bit as the frame is sent.
module tb_uart_tx;

  localparam int N = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic clk;
  logic rstN;
  int   checkCount;
  int   errorCount;
  logic [7:0] sb[$];

  uart_tx_if txBus ();

  uart_tx #(.CLKS_PER_BIT(N)) dut (
    .i_Clock (clk),
    .i_Rst_n (rstN),
    .tx_if   (txBus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level for serial bit position n of a frame carrying b.
  function automatic logic frameBit(logic [7:0] b, int n);
    logic r;
    r = 1'b1;
    if (n == 0) r = 1'b0;
    else if (n <= 8) r = b[n-1];
`ifdef UART_TX_PARITY_EN
    else if (n == 9) r = ^b;
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string tag, logic [7:0] observed, logic [7:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Presents a one-cycle request; returns just after the accepting edge.
  task automatic applyStimulus(logic [7:0] b, bit push);
    txBus.i_Tx_DV   = 1'b1;
    txBus.i_Tx_Byte = b;
    if (push) sb.push_back(b);
    tick();
    txBus.i_Tx_DV = 1'b0;
  endtask

  // Called just after the accepting edge; returns just after the CLEANUP edge.
  task automatic expectFrame();
    logic [7:0] b;
    if (sb.size() == 0) begin
      checkOutput("sb_underflow", 8'd0, 8'd1);
      return;
    end
    b = sb.pop_front();
    for (int c = 0; c < FRAME_BITS * N; c++) begin
      checkOutput("frame_serial", {7'd0, txBus.o_Tx_Serial}, {7'd0, frameBit(b, c / N)});
      checkOutput("frame_active", {7'd0, txBus.o_Tx_Active}, 8'd1);
      checkOutput("frame_done_low", {7'd0, txBus.o_Tx_Done}, 8'd0);
      tick();
    end
    checkOutput("done_pulse", {7'd0, txBus.o_Tx_Done}, 8'd1);
    checkOutput("active_end", {7'd0, txBus.o_Tx_Active}, 8'd0);
    checkOutput("serial_end", {7'd0, txBus.o_Tx_Serial}, 8'd1);
    tick();
    checkOutput("done_clear", {7'd0, txBus.o_Tx_Done}, 8'd0);
    checkOutput("serial_cleanup", {7'd0, txBus.o_Tx_Serial}, 8'd1);
  endtask

  task automatic checkIdle(string tag);
    checkOutput({tag, "_serial"}, {7'd0, txBus.o_Tx_Serial}, 8'd1);
    checkOutput({tag, "_active"}, {7'd0, txBus.o_Tx_Active}, 8'd0);
    checkOutput({tag, "_done"}, {7'd0, txBus.o_Tx_Done}, 8'd0);
  endtask

  initial begin
    checkCount      = 0;
    errorCount      = 0;
    rstN            = 1'b1;
    txBus.i_Enable  = 1'b0;
    txBus.i_Tx_DV   = 1'b0;
    txBus.i_Tx_Byte = 8'h00;

    $display("[TB] reset and idle line");
    #2 rstN = 1'b0;
    #1 checkIdle("reset");
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;
    txBus.i_Enable = 1'b1;
    checkIdle("release");
    for (int i = 0; i < 100; i++) begin
      tick();
      checkOutput("idle_serial", {7'd0, txBus.o_Tx_Serial}, 8'd1);
    end

    $display("[TB] single frame 0xA5");
    applyStimulus(8'hA5, 1'b1);
    expectFrame();

    $display("[TB] back-to-back 0x00 then 0xFF");
    txBus.i_Tx_DV   = 1'b1;
    txBus.i_Tx_Byte = 8'h00;
    sb.push_back(8'h00);
    tick();
    txBus.i_Tx_Byte = 8'hFF;
    sb.push_back(8'hFF);
    expectFrame();
    tick();
    txBus.i_Tx_DV = 1'b0;
    expectFrame();

    $display("[TB] request during frame is ignored");
    applyStimulus(8'h55, 1'b1);
    fork
      expectFrame();
      begin
        repeat (11) tick();
        txBus.i_Tx_DV   = 1'b1;
        txBus.i_Tx_Byte = 8'h3C;
        tick();
        txBus.i_Tx_DV = 1'b0;
      end
    join
    for (int i = 0; i < 20; i++) begin
      tick();
      checkIdle("after_ignored");
    end

    $display("[TB] abort by enable");
    applyStimulus(8'h96, 1'b0);
    repeat (19) tick();
    txBus.i_Enable = 1'b0;
    tick();
    checkIdle("abort");
    txBus.i_Tx_DV   = 1'b1;
    txBus.i_Tx_Byte = 8'h77;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkIdle("disabled");
    end
    txBus.i_Tx_DV  = 1'b0;
    txBus.i_Enable = 1'b1;
    tick();
    applyStimulus(8'hC3, 1'b1);
    expectFrame();

    $display("[TB] asynchronous reset mid-frame");
    applyStimulus(8'h3C, 1'b0);
    repeat (15) tick();
    #2 rstN = 1'b0;
    #1 checkIdle("async_reset");
    repeat (2) tick();
    rstN = 1'b1;
    tick();
    checkIdle("post_reset");
    applyStimulus(8'h81, 1'b1);
    expectFrame();

    checkOutput("sb_empty", 8'(sb.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
